// File: rtl/regfile_mp_if.sv
// Register file bus: write ports, read ports, scrub request and status.
// The bench drives the master side; regfile_mp takes the slave side.
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2
);
    localparam int AW = $clog2(NREG);

    logic                 clr_req;
    logic                 we0;
    logic [AW-1:0]        waddr0;
    logic [XLEN-1:0]      wdata0;
    logic                 we1;
    logic [AW-1:0]        waddr1;
    logic [XLEN-1:0]      wdata1;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*XLEN-1:0]  rdata;
    logic                 ready;
    logic                 wr_conflict;

    modport master (
        output clr_req, we0, waddr0, wdata0,
        output we1, waddr1, wdata1, raddr,
        input  rdata, ready, wr_conflict
    );

    modport slave (
        input  clr_req, we0, waddr0, wdata0,
        input  we1, waddr1, wdata1, raddr,
        output rdata, ready, wr_conflict
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD reads, two prioritised writes,
// optional write-to-read bypass, hardwired x0 and a sequential scrubber.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_mp_if.slave   io_rf
);
    localparam int AW = $clog2(NREG);

    localparam logic [0:0] S_SCRUB = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]          r_state;
    logic [AW-1:0]       r_idx;
    logic                r_conflict;
    logic [XLEN-1:0]     r_mem [NREG];

    logic                w_run;
    logic                w_commit;
    logic                w_eff0;
    logic                w_eff1;
    logic                w_same;
    logic [AW-1:0]       w_ra;
    logic [NRD*XLEN-1:0] w_rdata;

    // A write only counts once it will really be committed this edge.
    assign w_run    = (r_state == S_RUN);
    assign w_commit = w_run & ~io_rf.clr_req;
    assign w_eff0   = w_commit & io_rf.we0 & (io_rf.waddr0 != '0);
    assign w_eff1   = w_commit & io_rf.we1 & (io_rf.waddr1 != '0);
    assign w_same   = (io_rf.waddr0 == io_rf.waddr1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_SCRUB;
            r_idx      <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= w_eff0 & w_eff1 & w_same;
            unique case (r_state)
                S_SCRUB: begin
                    r_idx <= r_idx + AW'(1);
                    if (r_idx == AW'(NREG - 1)) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (io_rf.clr_req) begin
                        r_state <= S_SCRUB;
                        r_idx   <= '0;
                    end
                end
                default: r_state <= S_SCRUB;
            endcase
        end
    end

    // Array has no reset; the scrubber is what clears it.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_mem[r_idx] <= '0;
        end else begin
            if (w_eff0 && !(w_eff1 && w_same)) begin
                r_mem[io_rf.waddr0] <= io_rf.wdata0;
            end
            if (w_eff1) begin
                r_mem[io_rf.waddr1] <= io_rf.wdata1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        w_ra    = '0;
        for (int k = 0; k < NRD; k++) begin
            w_ra = io_rf.raddr[k*AW +: AW];
            if (w_run && (w_ra != '0)) begin
                if ((BYPASS != 0) && w_eff1 && (io_rf.waddr1 == w_ra)) begin
                    w_rdata[k*XLEN +: XLEN] = io_rf.wdata1;
                end else if ((BYPASS != 0) && w_eff0 && (io_rf.waddr0 == w_ra)) begin
                    w_rdata[k*XLEN +: XLEN] = io_rf.wdata0;
                end else begin
                    w_rdata[k*XLEN +: XLEN] = r_mem[w_ra];
                end
            end
        end
    end

    assign io_rf.rdata       = w_rdata;
    assign io_rf.ready       = w_run;
    assign io_rf.wr_conflict = r_conflict;
endmodule
